// File: rtl/ysyx_23060208_pkg.sv
// Shared types and constants for the ysyx_23060208 instruction fetch unit.
package ysyx_23060208_pkg;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060208_ifu_obuf.sv
// Single-entry output register holding one fetched instruction, its PC and fault flag.
module ysyx_23060208_ifu_obuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_flush,
  input  logic                  i_ready,
  input  logic [DATA_WIDTH-1:0] i_inst,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_fault,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_fault
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_inst;
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
      r_fault <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
      r_fault <= i_fault;
    end else if (i_flush || (r_valid && i_ready)) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_fault = r_fault;

endmodule

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch unit: single-outstanding SRAM read master feeding the IDU.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module ysyx_23060208_ifu_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = ysyx_23060208_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0]           perf_fetch_cnt,
  output logic [63:0]           perf_wait_cnt,
`endif
  output logic [DATA_WIDTH-1:0] isram_araddr,
  output logic                  isram_arvalid,
  input  logic                  isram_arready,
  input  logic [1:0]            isram_rresp,
  input  logic                  isram_rvalid,
  input  logic [DATA_WIDTH-1:0] isram_rdata,
  output logic                  isram_rready,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  ifu_valid,
  input  logic                  idu_ready,
  output logic [DATA_WIDTH-1:0] ifu_inst,
  output logic [DATA_WIDTH-1:0] ifu_pc,
  output logic                  ifu_fault
);

  import ysyx_23060208_pkg::*;

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  ifu_state_e            r_state;
  ifu_state_e            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_araddr;
  logic                  r_flush;
  logic                  w_flush_nxt;
  logic                  w_obuf_load;
  logic                  w_obuf_flush;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_fault;

  // Assert asynchronously, release two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign isram_arvalid = (r_state == AR);
  assign isram_rready  = (r_state == R);
  assign isram_araddr  = r_araddr;
  assign w_ar_hs       = isram_arvalid & isram_arready;
  assign w_r_hs        = isram_rvalid & isram_rready;
  assign w_fault       = (isram_rresp != RESP_OKAY);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_flush_nxt  = r_flush;
    w_obuf_load  = 1'b0;
    w_obuf_flush = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = AR;
      AR: begin
        if (w_ar_hs)        w_state_nxt = R;
        if (redirect_valid) w_flush_nxt = 1'b1;
      end
      R: begin
        if (w_r_hs) begin
          // A stale or just-redirected response is drained and dropped.
          if (r_flush || redirect_valid) begin
            w_flush_nxt = 1'b0;
            w_state_nxt = AR;
          end else begin
            w_obuf_load = 1'b1;
            w_pc_nxt    = r_pc + DATA_WIDTH'(4);
            w_state_nxt = OUT;
          end
        end else if (redirect_valid) begin
          w_flush_nxt = 1'b1;
        end
      end
      OUT: begin
        if (redirect_valid || (ifu_valid && idu_ready)) begin
          w_obuf_flush = redirect_valid;
          w_state_nxt  = AR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (redirect_valid) w_pc_nxt = redirect_pc;
  end

  // The request address is latched on entry to AR so it never moves while valid.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_flush  <= 1'b0;
      r_araddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flush <= w_flush_nxt;
      if ((w_state_nxt == AR) && (r_state != AR)) r_araddr <= w_pc_nxt;
    end
  end

  ysyx_23060208_ifu_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_load  (w_obuf_load),
    .i_flush (w_obuf_flush),
    .i_ready (idu_ready),
    .i_inst  (isram_rdata),
    .i_pc    (r_pc),
    .i_fault (w_fault),
    .o_valid (ifu_valid),
    .o_inst  (ifu_inst),
    .o_pc    (ifu_pc),
    .o_fault (ifu_fault)
  );

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (ifu_valid && idu_ready)           perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if ((r_state == AR) || (r_state == R)) perf_wait_cnt  <= perf_wait_cnt + 64'd1;
    end
  end
`endif

endmodule
